// File: rtl/ddr_burst_writer.sv
// Moves BURST_LEN-word bursts from a FWFT source FIFO into an MCB write port and issues one write command per burst.
// Optional statistics counters are built only when DDRWR_STATS_EN is defined.
module ddr_burst_writer #(
  parameter int          DATA_W       = 32,
  parameter int          BURST_LEN    = 64,
  parameter logic [29:0] BASE_ADDR    = 30'd0,
  parameter logic [31:0] REGION_BYTES = 32'h0400_0000
) (
  input  logic              ddr_usrclk,
  input  logic              ddr_usrreset,
  input  logic              arm_i,
  input  logic              circular_i,
  input  logic [31:0]       max_bursts_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic              src_burst_ok_i,
  output logic              src_rd_en_o,
  output logic              mcb_wr_en_o,
  output logic [DATA_W-1:0] mcb_wr_data_o,
  input  logic              mcb_wr_full_i,
  output logic              mcb_cmd_en_o,
  output logic [5:0]        mcb_cmd_bl_o,
  output logic [29:0]       mcb_cmd_byte_addr_o,
  input  logic              mcb_cmd_full_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              wrapped_o,
  output logic [29:0]       last_addr_o,
  output logic [31:0]       burst_count_o,
  output logic [31:0]       stall_count_o
);

  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * DATA_W / 8);
  localparam logic [31:0] END_ADDR    = {2'b00, BASE_ADDR} + REGION_BYTES;
  localparam logic [6:0]  LAST_WORD   = 7'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, WRITE, CMD, DONE} state_t;

  state_t      state, state_next;
  logic [29:0] next_addr;
  logic [29:0] last_addr;
  logic [31:0] burst_cnt;
  logic [31:0] max_bursts;
  logic        circular;
  logic        wrapped;
  logic [6:0]  word_cnt;
  logic [31:0] addr_sum;
  logic        at_end;
  logic        leave_idle;
  logic        push;
  logic        cmd_fire;

  // Sum kept 32 bits wide so the region end compares exactly even past 30-bit space
  assign addr_sum = {2'b00, next_addr} + BURST_BYTES;
  assign at_end   = (addr_sum == END_ADDR);

  always_comb begin
    state_next = state;
    leave_idle = 1'b0;
    push       = 1'b0;
    cmd_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (arm_i) begin
          leave_idle = 1'b1;
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (!arm_i || (!circular && burst_cnt == max_bursts))
          state_next = DONE;
        else if (src_burst_ok_i && !mcb_wr_full_i)
          state_next = WRITE;
      end
      WRITE: begin
        push = ~mcb_wr_full_i;
        if (push && word_cnt == LAST_WORD)
          state_next = CMD;
      end
      CMD: begin
        cmd_fire = ~mcb_cmd_full_i;
        if (cmd_fire)
          state_next = (at_end && !circular) ? DONE : WAIT_DATA;
      end
      DONE: begin
        if (!arm_i)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ddr_usrclk or posedge ddr_usrreset) begin
    if (ddr_usrreset) begin
      state      <= IDLE;
      next_addr  <= '0;
      last_addr  <= '0;
      burst_cnt  <= '0;
      max_bursts <= '0;
      circular   <= 1'b0;
      wrapped    <= 1'b0;
      word_cnt   <= '0;
    end else begin
      state <= state_next;
      if (leave_idle) begin
        next_addr  <= BASE_ADDR;
        burst_cnt  <= '0;
        wrapped    <= 1'b0;
        circular   <= circular_i;
        max_bursts <= max_bursts_i;
        word_cnt   <= '0;
      end
      if (push)
        word_cnt <= (word_cnt == LAST_WORD) ? 7'd0 : word_cnt + 7'd1;
      if (cmd_fire) begin
        last_addr <= next_addr;
        burst_cnt <= burst_cnt + 32'd1;
        next_addr <= (at_end && circular) ? BASE_ADDR : addr_sum[29:0];
        wrapped   <= wrapped | (at_end && circular);
      end
    end
  end

`ifdef DDRWR_STATS_EN
  logic [31:0] burst_stat;
  logic [31:0] stall_stat;

  always_ff @(posedge ddr_usrclk or posedge ddr_usrreset) begin
    if (ddr_usrreset) begin
      burst_stat <= '0;
      stall_stat <= '0;
    end else if (leave_idle) begin
      burst_stat <= '0;
      stall_stat <= '0;
    end else begin
      if (cmd_fire && burst_stat != 32'hFFFF_FFFF)
        burst_stat <= burst_stat + 32'd1;
      if (state == WRITE && mcb_wr_full_i && stall_stat != 32'hFFFF_FFFF)
        stall_stat <= stall_stat + 32'd1;
    end
  end

  assign burst_count_o = burst_stat;
  assign stall_count_o = stall_stat;
`else
  assign burst_count_o = 32'd0;
  assign stall_count_o = 32'd0;
`endif

  // Data path is a straight wire, forced low while reset is held
  assign mcb_wr_data_o       = ddr_usrreset ? '0 : src_data_i;
  assign src_rd_en_o         = push;
  assign mcb_wr_en_o         = push;
  assign mcb_cmd_en_o        = cmd_fire;
  assign mcb_cmd_bl_o        = 6'(BURST_LEN - 1);
  assign mcb_cmd_byte_addr_o = next_addr;
  assign busy_o              = (state == WAIT_DATA) || (state == WRITE) || (state == CMD);
  assign done_o              = (state == DONE);
  assign wrapped_o           = wrapped;
  assign last_addr_o         = last_addr;

endmodule

// File: tb/tb_ddr_burst_writer.sv
// Directed bench for ddr_burst_writer: BURST_LEN=4, DATA_W=32, 64-byte region at address 0.
// Stall counter expectations follow DDRWR_STATS_EN when the bench is built with that macro.
module tb_ddr_burst_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, circ;
  logic [31:0] max_bursts;
  logic [31:0] src_word = 32'h100;
  logic        src_ok, wr_full, cmd_full;
  logic        src_rd_en, mcb_wr_en, mcb_cmd_en;
  logic [31:0] mcb_wr_data;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_addr, last_addr;
  logic        busy, done, wrapped;
  logic [31:0] burst_count, stall_count;

  int checks = 0;
  int failures = 0;
  int push_cnt, hs_err, cyc = 0;
  bit done_seen;
  logic [31:0] push_data[$];
  int          push_cyc[$];
  logic [29:0] cmd_q[$];
  logic        wrap_q[$];

  localparam int W_PUSH = 0, W_CMD = 1, W_DONE = 2, W_IDLE = 3, W_SEEN = 4;

  always #5 clk = ~clk;

  ddr_burst_writer #(
    .DATA_W(32), .BURST_LEN(4), .BASE_ADDR(30'd0), .REGION_BYTES(32'd64)
  ) dut (
    .ddr_usrclk(clk), .ddr_usrreset(rst), .arm_i(arm), .circular_i(circ),
    .max_bursts_i(max_bursts), .src_data_i(src_word), .src_burst_ok_i(src_ok),
    .src_rd_en_o(src_rd_en), .mcb_wr_en_o(mcb_wr_en), .mcb_wr_data_o(mcb_wr_data),
    .mcb_wr_full_i(wr_full), .mcb_cmd_en_o(mcb_cmd_en), .mcb_cmd_bl_o(cmd_bl),
    .mcb_cmd_byte_addr_o(cmd_addr), .mcb_cmd_full_i(cmd_full), .busy_o(busy),
    .done_o(done), .wrapped_o(wrapped), .last_addr_o(last_addr),
    .burst_count_o(burst_count), .stall_count_o(stall_count)
  );

  // FWFT source model: head advances on each pop
  always @(posedge clk) if (src_rd_en) src_word <= src_word + 32'd1;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (src_rd_en !== mcb_wr_en) hs_err++;
      if (mcb_wr_data !== src_word) hs_err++;
      if (mcb_wr_en) begin
        push_cnt++;
        push_data.push_back(mcb_wr_data);
        push_cyc.push_back(cyc);
      end
      if (mcb_cmd_en) begin
        cmd_q.push_back(cmd_addr);
        wrap_q.push_back(wrapped);
      end
      if (done) done_seen = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    push_cnt = 0;
    hs_err = 0;
    done_seen = 1'b0;
    push_data.delete();
    push_cyc.delete();
    cmd_q.delete();
    wrap_q.delete();
  endtask

  function automatic logic [63:0] cmd_at(input int i);
    return (i < cmd_q.size()) ? 64'(cmd_q[i]) : 64'hDEAD;
  endfunction

  function automatic logic [63:0] wrap_at(input int i);
    return (i < wrap_q.size()) ? 64'(wrap_q[i]) : 64'hDEAD;
  endfunction

  function automatic logic [63:0] push_sum();
    logic [63:0] s = 0;
    foreach (push_data[i]) s += 64'(push_data[i]);
    return s;
  endfunction

  task automatic wait_until(input int what, input int n, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      case (what)
        W_PUSH:  hit = (push_cnt >= n);
        W_CMD:   hit = (cmd_q.size() >= n);
        W_DONE:  hit = done;
        W_IDLE:  hit = !busy && !done;
        W_SEEN:  hit = done_seen;
        default: hit = 1'b1;
      endcase
      if (hit) break;
    end
    check_eq({tag, "_reached"}, 64'(hit), 64'd1);
  endtask

  task automatic disarm(input string tag);
    @(posedge clk); #1;
    arm = 1'b0;
    wait_until(W_IDLE, 0, tag);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; circ = 1'b0; max_bursts = 0;
    src_ok = 1'b1; wr_full = 1'b0; cmd_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wrapped", wrapped, 0);
    check_eq("rst_last_addr", last_addr, 0);
    check_eq("rst_wr_en", mcb_wr_en, 0);
    check_eq("rst_cmd_en", mcb_cmd_en, 0);
    check_eq("rst_wr_data", mcb_wr_data, 0);
    check_eq("rst_cmd_bl", cmd_bl, 3);
    @(posedge clk); #1;
    rst = 1'b0;

    // Linear, three bursts
    clear_log(); max_bursts = 3; arm = 1'b1;
    wait_until(W_DONE, 0, "lin3");
    check_eq("lin3_pushes", push_cnt, 12);
    check_eq("lin3_data_sum", push_sum(), 64'hC42);
    check_eq("lin3_ncmd", cmd_q.size(), 3);
    check_eq("lin3_cmd0", cmd_at(0), 64'h00);
    check_eq("lin3_cmd1", cmd_at(1), 64'h10);
    check_eq("lin3_cmd2", cmd_at(2), 64'h20);
    check_eq("lin3_bl", cmd_bl, 3);
    check_eq("lin3_last_addr", last_addr, 30'h20);
    check_eq("lin3_busy", busy, 0);
    check_eq("lin3_wrapped", wrapped, 0);
    check_eq("lin3_handshake", hs_err, 0);
    disarm("lin3_idle");

    // Write FIFO full for two cycles mid-burst
    clear_log(); max_bursts = 1; arm = 1'b1;
    wait_until(W_PUSH, 2, "stall_p2");
    @(posedge clk); #1;
    wr_full = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr_full = 1'b0;
    wait_until(W_DONE, 0, "stall");
    check_eq("stall_pushes", push_cnt, 4);
    check_eq("stall_ncmd", cmd_q.size(), 1);
    check_eq("stall_gap", (push_cyc.size() > 2) ? 64'(push_cyc[2] - push_cyc[1]) : 64'hDEAD, 3);
`ifdef DDRWR_STATS_EN
    check_eq("stall_count", stall_count, 2);
    check_eq("stall_bursts", burst_count, 1);
`else
    check_eq("stall_count_tied", stall_count, 0);
    check_eq("burst_count_tied", burst_count, 0);
`endif
    disarm("stall_idle");

    // Ring mode over a four-burst region
    clear_log(); circ = 1'b1; max_bursts = 0; arm = 1'b1;
    wait_until(W_CMD, 5, "ring");
    @(posedge clk); #1;
    arm = 1'b0;
    wait_until(W_IDLE, 0, "ring_idle");
    check_eq("ring_ncmd", cmd_q.size(), 5);
    check_eq("ring_cmd0", cmd_at(0), 64'h00);
    check_eq("ring_cmd1", cmd_at(1), 64'h10);
    check_eq("ring_cmd2", cmd_at(2), 64'h20);
    check_eq("ring_cmd3", cmd_at(3), 64'h30);
    check_eq("ring_cmd4", cmd_at(4), 64'h00);
    check_eq("ring_wrap_at4", wrap_at(3), 0);
    check_eq("ring_wrap_at5", wrap_at(4), 1);
    check_eq("ring_wrapped", wrapped, 1);
    check_eq("ring_done_seen", done_seen, 1);

    // Linear run hitting the region end before the limit
    clear_log(); circ = 1'b0; max_bursts = 100; arm = 1'b1;
    wait_until(W_DONE, 0, "end");
    check_eq("end_ncmd", cmd_q.size(), 4);
    check_eq("end_pushes", push_cnt, 16);
    check_eq("end_last_addr", last_addr, 30'h30);
    check_eq("end_wrapped", wrapped, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("end_hold_done", done, 1);
    disarm("end_idle");

    // arm dropped after the second word
    clear_log(); max_bursts = 5; arm = 1'b1;
    wait_until(W_PUSH, 2, "drop_p2");
    @(posedge clk); #1;
    arm = 1'b0;
    wait_until(W_SEEN, 0, "drop_done");
    wait_until(W_IDLE, 0, "drop_idle");
    check_eq("drop_pushes", push_cnt, 4);
    check_eq("drop_ncmd", cmd_q.size(), 1);
    check_eq("drop_cmd0", cmd_at(0), 64'h00);

    // Reset during the second burst's WRITE
    clear_log(); max_bursts = 2; arm = 1'b1;
    wait_until(W_PUSH, 6, "rstw_p6");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("rstw_wr_en", mcb_wr_en, 0);
    check_eq("rstw_rd_en", src_rd_en, 0);
    check_eq("rstw_cmd_en", mcb_cmd_en, 0);
    check_eq("rstw_busy", busy, 0);
    check_eq("rstw_wr_data", mcb_wr_data, 0);
    check_eq("rstw_cmd_addr", cmd_addr, 0);
    @(posedge clk); #1;
    clear_log(); max_bursts = 1;
    rst = 1'b0;
    wait_until(W_CMD, 1, "rstw_rearm");
    check_eq("rstw_restart_addr", cmd_at(0), 64'h00);
    wait_until(W_DONE, 0, "rstw_done");
    disarm("rstw_idle");

    // Linear limit of zero
    clear_log(); max_bursts = 0; arm = 1'b1;
    wait_until(W_DONE, 0, "max0");
    check_eq("max0_pushes", push_cnt, 0);
    check_eq("max0_ncmd", cmd_q.size(), 0);
    disarm("max0_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
